// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

    localparam int OFFSET_WIDTH = 16;
    localparam int INDEX_WIDTH  = 26;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: exception, misaligned JR trap, JR, J/JAL, branch, sequential.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic [ADDR_WIDTH-1:0]   i_pc,
    input  logic                    i_exception,
    input  logic                    i_jump_reg,
    input  logic [ADDR_WIDTH-1:0]   i_jr_addr,
    input  logic                    i_jump,
    input  logic [INDEX_WIDTH-1:0]  i_jump_index,
    input  logic                    i_branch_taken,
    input  logic [OFFSET_WIDTH-1:0] i_branch_offset,
    output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]   o_next_pc,
    output logic                    o_take_trap,
    output logic                    o_misalign
);

    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_branch_bytes;
    logic [ADDR_WIDTH-1:0] w_jump_target;
    logic                  w_jr_misaligned;

    // The word offset is sign-extended and scaled to bytes in one concatenation.
    assign w_pc_plus4      = i_pc + ADDR_WIDTH'(4);
    assign w_branch_bytes  = {{(ADDR_WIDTH-OFFSET_WIDTH-2){i_branch_offset[OFFSET_WIDTH-1]}},
                              i_branch_offset, 2'b00};
    assign w_jump_target   = {w_pc_plus4[ADDR_WIDTH-1:28], i_jump_index, 2'b00};
    assign w_jr_misaligned = i_jump_reg && (i_jr_addr[1:0] != 2'b00);
    assign o_pc_plus4      = w_pc_plus4;

    // Strict priority selection; simultaneous selects are legal and resolve here.
    always_comb begin
        o_next_pc   = w_pc_plus4;
        o_take_trap = 1'b0;
        o_misalign  = 1'b0;
        if (i_exception) begin
            o_next_pc   = EXC_VECTOR;
            o_take_trap = 1'b1;
        end else if (w_jr_misaligned) begin
            o_next_pc   = EXC_VECTOR;
            o_take_trap = 1'b1;
            o_misalign  = 1'b1;
        end else if (i_jump_reg) begin
            o_next_pc = i_jr_addr;
        end else if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (i_branch_taken) begin
            o_next_pc = w_pc_plus4 + w_branch_bytes;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALTED control around the registered fetch address.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEF_RESET_ADDR),
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic                    halt,
    input  logic                    resume,
    input  logic                    branch_taken,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    jump,
    input  logic [INDEX_WIDTH-1:0]  jump_index,
    input  logic                    jump_reg,
    input  logic [ADDR_WIDTH-1:0]   jr_addr,
    input  logic                    exception,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic [ADDR_WIDTH-1:0]   pc_plus4,
    output logic                    pc_valid,
    output logic [ADDR_WIDTH-1:0]   epc,
    output logic                    misaligned
);

    pc_state_t             r_state;
    pc_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_epc;
    logic                  r_valid;
    logic                  r_misaligned;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] w_epc_next;
    logic                  w_valid_next;
    logic                  w_misaligned_next;
    logic [ADDR_WIDTH-1:0] w_sel_pc;
    logic                  w_take_trap;
    logic                  w_misalign;

    pc_next_sel #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .i_pc            (r_pc),
        .i_exception     (exception),
        .i_jump_reg      (jump_reg),
        .i_jr_addr       (jr_addr),
        .i_jump          (jump),
        .i_jump_index    (jump_index),
        .i_branch_taken  (branch_taken),
        .i_branch_offset (branch_offset),
        .o_pc_plus4      (pc_plus4),
        .o_next_pc       (w_sel_pc),
        .o_take_trap     (w_take_trap),
        .o_misalign      (w_misalign)
    );

    // State register; reset always returns to BOOT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-register logic; exception outranks halt, halt outranks stall.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_epc_next        = r_epc;
        w_valid_next      = r_valid;
        w_misaligned_next = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
                w_pc_next    = RESET_ADDR;
                w_valid_next = 1'b1;
            end
            RUN: begin
                if (exception) begin
                    w_pc_next  = w_sel_pc;
                    w_epc_next = r_pc;
                end else if (halt) begin
                    w_state_next = HALTED;
                    w_valid_next = 1'b0;
                end else if (!stall) begin
                    w_pc_next = w_sel_pc;
                    if (w_take_trap) begin
                        w_epc_next        = r_pc;
                        w_misaligned_next = w_misalign;
                    end
                end
            end
            HALTED: begin
                if (exception) begin
                    w_state_next = RUN;
                    w_pc_next    = EXC_VECTOR;
                    w_epc_next   = r_pc;
                    w_valid_next = 1'b1;
                end else if (resume) begin
                    w_state_next = RUN;
                    w_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = BOOT;
                w_pc_next    = RESET_ADDR;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // Datapath registers: fetch address, trap PC, valid flag and the misalignment pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_ADDR;
            r_epc        <= '0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_epc        <= w_epc_next;
            r_valid      <= w_valid_next;
            r_misaligned <= w_misaligned_next;
        end
    end

    assign pc         = r_pc;
    assign epc        = r_epc;
    assign pc_valid   = r_valid;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with hand-computed expected values.
module tb_pc_unit;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_addr;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic [31:0] epc;
    logic        misaligned;

    int nChecks = 0;
    int nFails  = 0;

    pc_unit #(
        .ADDR_WIDTH (32),
        .RESET_ADDR (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .halt          (halt),
        .resume        (resume),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
        .exception     (exception),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .epc           (epc),
        .misaligned    (misaligned)
    );

    // Free-running 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drop every select back to idle.
    task automatic clearInputs();
        stall         = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0000;
        jump          = 1'b0;
        jump_index    = 26'h0;
        jump_reg      = 1'b0;
        jr_addr       = 32'h0;
        exception     = 1'b0;
    endtask

    // Advance one rising edge and settle 1 unit past it.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        reset_n = 1'b0;
        #12;
        nChecks++;
        if (pc !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 32'h0); end
        nChecks++;
        if (pc_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", pc_valid); end
        nChecks++;
        if (epc !== 32'h0 || misaligned !== 1'b0) begin
            nFails++; $display("[TB] FAIL reset_epc_mis: got %h/%b want 0/0", epc, misaligned);
        end
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus();
        nChecks++;
        if (pc !== 32'h0 || pc_valid !== 1'b1) begin
            nFails++; $display("[TB] FAIL boot_edge: got pc=%h valid=%b want 0/1", pc, pc_valid);
        end
        applyStimulus();
        nChecks++;
        if (pc !== 32'h4 || pc_plus4 !== 32'h8) begin
            nFails++; $display("[TB] FAIL first_seq: got pc=%h plus4=%h want 4/8", pc, pc_plus4);
        end
    endtask

    task automatic test_branch();
        jump_reg = 1'b1; jr_addr = 32'h0000_0100;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h100) begin nFails++; $display("[TB] FAIL jr_0x100: got %h want 100", pc); end
        branch_taken = 1'b1; branch_offset = 16'hFFFF;
        applyStimulus();
        nChecks++;
        if (pc !== 32'h100) begin nFails++; $display("[TB] FAIL branch_neg: got %h want 100", pc); end
        branch_offset = 16'h0003;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h110) begin nFails++; $display("[TB] FAIL branch_pos: got %h want 110", pc); end
    endtask

    task automatic test_jump();
        jump_reg = 1'b1; jr_addr = 32'hA000_0000;
        applyStimulus();
        clearInputs();
        jump = 1'b1; jump_index = 26'h0000010;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'hA000_0040) begin nFails++; $display("[TB] FAIL jump_target: got %h want a0000040", pc); end
        jump_reg = 1'b1; jr_addr = 32'h0000_2000;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h2000) begin nFails++; $display("[TB] FAIL jr_aligned: got %h want 2000", pc); end
    endtask

    task automatic test_misaligned();
        jump_reg = 1'b1; jr_addr = 32'h0000_2002;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h80 || epc !== 32'h2000 || misaligned !== 1'b1) begin
            nFails++; $display("[TB] FAIL jr_trap: got pc=%h epc=%h mis=%b want 80/2000/1", pc, epc, misaligned);
        end
        applyStimulus();
        nChecks++;
        if (pc !== 32'h84 || misaligned !== 1'b0) begin
            nFails++; $display("[TB] FAIL jr_trap_pulse: got pc=%h mis=%b want 84/0", pc, misaligned);
        end
    endtask

    task automatic test_stall_halt();
        stall = 1'b1; jump = 1'b1; jump_index = 26'h00003FF;
        applyStimulus();
        nChecks++;
        if (pc !== 32'h84) begin nFails++; $display("[TB] FAIL stall_jump: got %h want 84", pc); end
        jump = 1'b0; jump_reg = 1'b1; jr_addr = 32'h0000_0003;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h84 || misaligned !== 1'b0 || epc !== 32'h2000) begin
            nFails++; $display("[TB] FAIL stall_jr_trap: got pc=%h mis=%b epc=%h want 84/0/2000", pc, misaligned, epc);
        end
        jump_reg = 1'b1; jr_addr = 32'h0000_0040;
        applyStimulus();
        clearInputs();
        halt = 1'b1;
        applyStimulus();
        halt = 1'b0;
        nChecks++;
        if (pc !== 32'h40 || pc_valid !== 1'b0) begin
            nFails++; $display("[TB] FAIL halt_enter: got pc=%h valid=%b want 40/0", pc, pc_valid);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            nChecks++;
            if (pc !== 32'h40 || pc_valid !== 1'b0) begin
                nFails++; $display("[TB] FAIL halt_hold%0d: got pc=%h valid=%b want 40/0", i, pc, pc_valid);
            end
        end
        resume = 1'b1;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h40 || pc_valid !== 1'b1) begin
            nFails++; $display("[TB] FAIL resume: got pc=%h valid=%b want 40/1", pc, pc_valid);
        end
        applyStimulus();
        nChecks++;
        if (pc !== 32'h44) begin nFails++; $display("[TB] FAIL after_resume: got %h want 44", pc); end
        stall = 1'b1; exception = 1'b1;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h80 || epc !== 32'h44) begin
            nFails++; $display("[TB] FAIL exc_over_stall: got pc=%h epc=%h want 80/44", pc, epc);
        end
        applyStimulus();
        halt = 1'b1;
        applyStimulus();
        clearInputs();
        exception = 1'b1; resume = 1'b1;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h80 || epc !== 32'h84 || pc_valid !== 1'b1) begin
            nFails++; $display("[TB] FAIL halted_exc: got pc=%h epc=%h valid=%b want 80/84/1", pc, epc, pc_valid);
        end
    endtask

    task automatic test_priority();
        exception = 1'b1; jump_reg = 1'b1; jr_addr = 32'h0000_2002;
        jump = 1'b1; jump_index = 26'h5; branch_taken = 1'b1; branch_offset = 16'h0001;
        applyStimulus();
        nChecks++;
        if (pc !== 32'h80 || misaligned !== 1'b0 || epc !== 32'h80) begin
            nFails++; $display("[TB] FAIL prio_exc: got pc=%h mis=%b epc=%h want 80/0/80", pc, misaligned, epc);
        end
        exception = 1'b0; jr_addr = 32'h0000_1000;
        applyStimulus();
        nChecks++;
        if (pc !== 32'h1000) begin nFails++; $display("[TB] FAIL prio_jr: got %h want 1000", pc); end
        jump_reg = 1'b0; jump_index = 26'h20;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc !== 32'h80) begin nFails++; $display("[TB] FAIL prio_jump: got %h want 80", pc); end
    endtask

    task automatic test_wrap();
        jump_reg = 1'b1; jr_addr = 32'hFFFF_FFFC;
        applyStimulus();
        clearInputs();
        nChecks++;
        if (pc_plus4 !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_plus4: got %h want 0", pc_plus4); end
        applyStimulus();
        nChecks++;
        if (pc !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_pc: got %h want 0", pc); end
    endtask

    task automatic test_async_reset();
        applyStimulus();
        nChecks++;
        if (pc !== 32'h4) begin nFails++; $display("[TB] FAIL pre_reset: got %h want 4", pc); end
        #2;
        reset_n = 1'b0;
        #1;
        nChecks++;
        if (pc !== 32'h0 || pc_valid !== 1'b0 || epc !== 32'h0) begin
            nFails++; $display("[TB] FAIL async_reset: got pc=%h valid=%b epc=%h want 0/0/0", pc, pc_valid, epc);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus();
        nChecks++;
        if (pc !== 32'h0 || pc_valid !== 1'b1) begin
            nFails++; $display("[TB] FAIL reboot: got pc=%h valid=%b want 0/1", pc, pc_valid);
        end
        applyStimulus();
        nChecks++;
        if (pc !== 32'h4) begin nFails++; $display("[TB] FAIL reboot_seq: got %h want 4", pc); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_misaligned();
        test_stall_halt();
        test_priority();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle MIPS core: holds the fetch address and computes the next PC from sequential, branch, jump, jump-register and exception sources. It also handles stall, halt/resume, a boot cycle after reset, and jump-register misalignment trapping. It replaces the plain address register in front of instruction memory. The datapath and control unit drive its select inputs from the decoded instruction.

## Interface
- ADDR_WIDTH, 32, PC width in bits; legal range 30..64.
- RESET_ADDR, 0, PC value after reset; must be a multiple of 4.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception or misaligned jump-register; must be a multiple of 4.

- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC this cycle (pipeline/memory wait).
- halt  in  1  enter HALTED.
- resume  in  1  leave HALTED.
- branch_taken  in  1  select branch target.
- branch_offset  in  16  signed word offset (instruction imm16).
- jump  in  1  select J/JAL target.
- jump_index  in  26  instruction index field.
- jump_reg  in  1  select JR/JALR target.
- jr_addr  in  ADDR_WIDTH  register target address.
- exception  in  1  external trap request.
- pc  out  ADDR_WIDTH  current fetch address.
- pc_plus4  out  ADDR_WIDTH  pc + 4, combinational from pc.
- pc_valid  out  1  pc is a real fetch address.
- epc  out  ADDR_WIDTH  PC of the trapping instruction.
- misaligned  out  1  one-cycle pulse on a JR trap.

## Operation
- States: BOOT, RUN, HALTED.
- Reset (asynchronous, any state, including mid-operation):
  - state = BOOT, pc = RESET_ADDR, pc_valid = 0, epc = 0, misaligned = 0.
- BOOT:
  - The first rising edge with reset_n high moves to RUN.
  - pc stays RESET_ADDR and pc_valid becomes 1.
  - All other inputs are ignored in BOOT.
- RUN, next-PC selection (highest priority first):
  1. exception: pc = EXC_VECTOR, epc = pc.
  2. jump_reg with jr_addr[1:0] != 0: pc = EXC_VECTOR, epc = pc, misaligned = 1 for that cycle.
  3. jump_reg (aligned): pc = jr_addr.
  4. jump: pc = {pc_plus4[ADDR_WIDTH-1:28], jump_index, 2'b00}.
  5. branch_taken: pc = pc_plus4 + (sign-extended branch_offset << 2).
  6. Otherwise: pc = pc_plus4.
- stall in RUN holds pc and epc unchanged.
  - exception overrides stall.
  - A misaligned JR under stall is not taken.
- halt in RUN (not outranked by exception): move to HALTED, pc held, pc_valid = 0.
- HALTED:
  - pc and epc are held.
  - resume: move to RUN with pc unchanged, pc_valid = 1.
  - exception: move to RUN with pc = EXC_VECTOR, epc = held pc.
  - exception beats resume.
- Arithmetic:
  - All additions are modulo 2^ADDR_WIDTH; wrap-around is silent.
  - Sign extension is to ADDR_WIDTH.
- Multiple selects asserted together resolve strictly by the priority list; this is not an error.

## Timing
- pc is registered; every update takes effect on the edge after the inputs are sampled (one-cycle latency).
- pc_plus4 is combinational from pc; it has no added latency.
- misaligned is registered and high for exactly one cycle, aligned with pc == EXC_VECTOR.
- pc_valid is registered.
- Reset takes effect immediately on reset_n falling; release is synchronous through BOOT.

## Structure
- Shared package pc_pkg: state enum (BOOT, RUN, HALTED), the default EXC_VECTOR and RESET_ADDR constants, and the instruction-field widths (16 for offset, 26 for index).
- One natural sub-module: pc_next_sel. It is the combinational priority mux and adders, producing next_pc, take_trap and misalign.
- pc_unit keeps the state register, pc, epc, pc_valid and misaligned.

## Test plan
- Reset then release: pc = 0 and pc_valid = 0 during reset; after the first edge pc = 0, pc_valid = 1; after the second edge pc = 4.
- Sequential and branch: from pc = 0x100, assert branch_taken with offset 0xFFFF → pc = 0x100; with offset 0x0003 → pc = 0x110.
- Jump and JR: from pc = 0xA000_0000, jump_index = 0x0000010 → pc = 0xA000_0040. Then jr_addr = 0x0000_2000 → pc = 0x2000.
- Misaligned JR: from pc = 0x2000, jr_addr = 0x0000_2002 → pc = 0x80, epc = 0x2000, misaligned high for exactly one cycle.
- Stall, halt and exception: a stall with jump held keeps pc. Halt at pc = 0x40 → pc_valid = 0 and pc held for 5 cycles; resume → pc = 0x40, then 0x44. An exception during stall → pc = 0x80.
- Wrap and async reset: at pc = 0xFFFF_FFFC, sequential → pc = 0. Asserting reset_n low mid-cycle → pc = RESET_ADDR immediately, with no clock edge.
